// File: rtl/ysyx_24110006_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_ifu -- instruction fetch unit
//
// Fetches one instruction per next-PC strobe. It issues a read request at the
// current PC and waits for the read data. It latches the instruction together
// with its decoded immediate and presents them to decode for one cycle. It
// then waits in DONE until writeback supplies the next PC.
//
// Ports
//   i_clock       sole clock, all state updates on its rising edge
//   i_reset       synchronous, active-high reset
//   o_mem_req     read request, high only while in REQ
//   o_mem_addr    read address (always equals PC)
//   i_mem_ready   memory accepts the request this cycle
//   i_mem_rvalid  read data valid (only sampled in WAIT)
//   i_mem_rdata   instruction word
//   i_pc_valid    next-PC strobe from writeback (only sampled in DONE)
//   i_dnpc        next PC
//   o_inst        fetched instruction (registered)
//   o_imm         immediate decoded from o_inst (registered)
//   o_pc          PC of o_inst
//   o_valid       one-cycle pulse marking o_inst/o_imm/o_pc valid
//   o_fault       sticky misaligned next-PC fault
//
// Build option
//   YSYX_24110006_IFU_ALIGN_CHECK_EN  defined: a next PC with i_dnpc[1:0] != 0
//   moves the unit into FAULT. FAULT raises o_fault and stops fetching until
//   reset. When the macro is undefined, i_dnpc is loaded unchecked and o_fault
//   is tied low.
// ---------------------------------------------------------------------------
module ysyx_24110006_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_pc_valid,
  input  logic [31:0] i_dnpc,
  output logic [31:0] o_inst,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic        o_valid,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  // RV32 major opcodes that carry an immediate.
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] imm_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] imm_d;

  // -------------------------------------------------------------------------
  // Immediate decode of the incoming read data. It is computed in front of
  // the capture register so that o_imm lines up with o_inst in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every path gets a value from this default first, so no latch can be
    // inferred when the opcode matches none of the listed formats.
    imm_d = 32'h0;
    unique case (i_mem_rdata[6:0])
      OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM:
        imm_d = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:20]};
      OP_LUI, OP_AUIPC:
        imm_d = {i_mem_rdata[31:12], 12'b0};
      OP_JAL:
        imm_d = {{11{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[19:12],
                 i_mem_rdata[20], i_mem_rdata[30:21], 1'b0};
      OP_STORE:
        imm_d = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:25], i_mem_rdata[11:7]};
      OP_BRANCH:
        imm_d = {{19{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[7],
                 i_mem_rdata[30:25], i_mem_rdata[11:8], 1'b0};
      OP_REG:
        // funct7 is passed through for the R-type datapath.
        imm_d = {25'b0, i_mem_rdata[31:25]};
      default:
        imm_d = 32'h0;
    endcase
  end

`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
  logic fault_q;
  logic dnpc_misaligned;

  assign dnpc_misaligned = |i_dnpc[1:0];
`endif

  // -------------------------------------------------------------------------
  // Fetch FSM. Output flags are registered together with the state, so they
  // are set on the transition into the state that owns them. For example,
  // req_q is raised on every transition into S_REQ and is cleared on exit.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: state uses non-blocking assignments so that every register in
      // this block samples pre-edge values, independent of statement order.
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      imm_q   <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end

        S_REQ: begin
          // If rvalid arrives together with ready, it is not captured here.
          // The read data is taken in WAIT at the earliest.
          if (i_mem_ready) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end

        S_WAIT: begin
          if (i_mem_rvalid) begin
            inst_q  <= i_mem_rdata;
            imm_q   <= imm_d;
            valid_q <= 1'b1;
            state_q <= S_VALID;
          end
        end

        S_VALID: begin
          valid_q <= 1'b0;
          state_q <= S_DONE;
        end

        S_DONE: begin
          if (i_pc_valid) begin
`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
            if (dnpc_misaligned) begin
              // PC keeps the last good value for post-mortem inspection.
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              pc_q    <= i_dnpc;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
`else
            pc_q    <= i_dnpc;
            req_q   <= 1'b1;
            state_q <= S_REQ;
`endif
          end
        end

        // Terminal until reset. This state is unreachable without the
        // alignment check.
        S_FAULT: begin
          state_q <= S_FAULT;
        end

        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req  = req_q;
  assign o_mem_addr = pc_q;
  assign o_inst     = inst_q;
  assign o_imm      = imm_q;
  assign o_pc       = pc_q;
  assign o_valid    = valid_q;

`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Self-checking bench for ysyx_24110006_ifu. Inputs are driven, and outputs
// sampled, 1 time unit after each rising clock edge.
module tb_ysyx_24110006_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_pc_valid;
  logic [31:0] i_dnpc;
  logic [31:0] o_inst;
  logic [31:0] o_imm;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_24110006_ifu #(.RESET_PC(RESET_PC)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ready (i_mem_ready),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata),
    .i_pc_valid  (i_pc_valid),
    .i_dnpc      (i_dnpc),
    .o_inst      (o_inst),
    .o_imm       (o_imm),
    .o_pc        (o_pc),
    .o_valid     (o_valid),
    .o_fault     (o_fault)
  );

  // Reference immediate: plain arithmetic on the instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] inst);
    logic [31:0] op;
    logic [31:0] r;
    op = inst & 32'h7f;
    r  = 32'h0;
    case (op)
      32'h13, 32'h67, 32'h03, 32'h73: r = $signed(inst) >>> 20;
      32'h37, 32'h17:                 r = inst & 32'hFFFF_F000;
      32'h6F: begin
        if (inst[31]) r = 32'hFFF0_0000;
        r = r + (((inst >> 12) & 32'hff)  << 12)
              + (((inst >> 20) & 32'h1)   << 11)
              + (((inst >> 21) & 32'h3ff) << 1);
      end
      32'h23: begin
        if (inst[31]) r = 32'hFFFF_F000;
        r = r + (((inst >> 25) & 32'h7f) << 5) + ((inst >> 7) & 32'h1f);
      end
      32'h63: begin
        if (inst[31]) r = 32'hFFFF_F000;
        r = r + (((inst >> 7)  & 32'h1)  << 11)
              + (((inst >> 25) & 32'h3f) << 5)
              + (((inst >> 8)  & 32'hf)  << 1);
      end
      32'h33:  r = inst >> 25;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;
    i_pc_valid   = 1'b0;
    i_dnpc       = 32'h0;
    step();
    step();
    i_reset = 1'b0;
  endtask

  // Completes one fetch at exp_pc and returns with the unit sitting in DONE.
  task automatic run_fetch(input string tag, input logic [31:0] exp_pc,
                           input logic [31:0] inst, input int ready_wait,
                           input int rvalid_wait);
    int budget;
    logic [31:0] exp_imm;
    exp_imm = ref_imm(inst);
    budget  = 0;
    while (o_mem_req !== 1'b1 && budget < 8) begin
      step();
      budget++;
    end
    vectors++;
    if (o_mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL %s req_timeout: o_mem_req=%b expected 1", tag, o_mem_req);
      return;
    end
    vectors++;
    if (o_mem_addr !== exp_pc) begin
      miscompares++;
      $display("FAIL %s addr: got %h expected %h", tag, o_mem_addr, exp_pc);
    end
    i_mem_ready = 1'b0;
    for (int k = 0; k < ready_wait; k++) begin
      i_mem_rvalid = 1'($urandom_range(0, 1));
      i_mem_rdata  = $urandom;
      step();
      vectors++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== exp_pc || o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s stall%0d: req=%b addr=%h valid=%b expected 1/%h/0",
                 tag, k, o_mem_req, o_mem_addr, o_valid, exp_pc);
      end
    end
    // rvalid together with ready must not be captured as the instruction.
    i_mem_ready  = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = ~inst;
    step();
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    vectors++;
    if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handshake: req=%b valid=%b expected 0/0", tag, o_mem_req, o_valid);
    end
    for (int k = 0; k < rvalid_wait; k++) begin
      i_pc_valid = 1'($urandom_range(0, 1));
      i_dnpc     = $urandom;
      step();
      vectors++;
      if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s wait%0d: req=%b valid=%b expected 0/0", tag, k, o_mem_req, o_valid);
      end
    end
    i_pc_valid   = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = inst;
    step();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = $urandom;
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s valid: got %b expected 1", tag, o_valid);
    end
    vectors++;
    if (o_inst !== inst) begin
      miscompares++;
      $display("FAIL %s inst: got %h expected %h", tag, o_inst, inst);
    end
    vectors++;
    if (o_imm !== exp_imm) begin
      miscompares++;
      $display("FAIL %s imm: got %h expected %h (inst %h)", tag, o_imm, exp_imm, inst);
    end
    vectors++;
    if (o_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL %s pc: got %h expected %h", tag, o_pc, exp_pc);
    end
    step();
    vectors++;
    if (o_valid !== 1'b0 || o_inst !== inst || o_imm !== exp_imm || o_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL %s done_hold: valid=%b inst=%h imm=%h pc=%h expected 0/%h/%h/%h",
               tag, o_valid, o_inst, o_imm, o_pc, inst, exp_imm, exp_pc);
    end
  endtask

  task automatic issue_dnpc(input logic [31:0] next_pc);
    i_pc_valid = 1'b1;
    i_dnpc     = next_pc;
    step();
    i_pc_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_mem_ready  = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFFFF_FFFF;
    i_pc_valid   = 1'b1;
    i_dnpc       = 32'h1234_5678;
    i_reset      = 1'b1;
    step();
    step();
    vectors++;
    if (o_mem_req !== 1'b0 || o_valid !== 1'b0 || o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: req=%b valid=%b fault=%b expected 0/0/0",
               o_mem_req, o_valid, o_fault);
    end
    vectors++;
    if (o_inst !== 32'h0 || o_imm !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: inst=%h imm=%h expected 0/0", o_inst, o_imm);
    end
    vectors++;
    if (o_pc !== RESET_PC || o_mem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL reset_pc: pc=%h addr=%h expected %h", o_pc, o_mem_addr, RESET_PC);
    end
  endtask

  // After reset release: BOOT, REQ, WAIT, VALID. o_valid appears on the
  // third edge and lasts exactly one cycle.
  task automatic test_basic_fetch();
    do_reset();
    i_mem_ready  = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0050_0093;
    step();
    vectors++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8000_0000 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_req: req=%b addr=%h valid=%b expected 1/80000000/0",
               o_mem_req, o_mem_addr, o_valid);
    end
    step();
    vectors++;
    if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait: req=%b valid=%b expected 0/0", o_mem_req, o_valid);
    end
    step();
    vectors++;
    if (o_valid !== 1'b1 || o_inst !== 32'h0050_0093 || o_imm !== 32'h5 ||
        o_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL basic_valid: valid=%b inst=%h imm=%h pc=%h expected 1/00500093/5/80000000",
               o_valid, o_inst, o_imm, o_pc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (o_valid !== 1'b0 || o_mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_after%0d: valid=%b req=%b expected 0/0", k, o_valid, o_mem_req);
      end
    end
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
  endtask

  task automatic test_ready_stall();
    do_reset();
    run_fetch("stall4", RESET_PC, 32'h0010_0113, 4, 0);
    issue_dnpc(32'h8000_0008);
    run_fetch("stall2", 32'h8000_0008, 32'h0020_0193, 2, 3);
  endtask

  task automatic test_imm_table();
    logic [31:0] insts [6];
    logic [31:0] imms  [6];
    logic [31:0] pc;
    insts = '{32'hFFF0_0113, 32'h1234_52B7, 32'hFE00_0EE3,
              32'h0000_006F, 32'h4000_0033, 32'h0000_000B};
    imms  = '{32'hFFFF_FFFF, 32'h1234_5000, 32'hFFFF_FFFC,
              32'h0000_0000, 32'h0000_0020, 32'h0000_0000};
    do_reset();
    pc = RESET_PC;
    for (int i = 0; i < 6; i++) begin
      run_fetch("imm_table", pc, insts[i], 0, 0);
      vectors++;
      if (o_imm !== imms[i]) begin
        miscompares++;
        $display("FAIL imm_table[%0d]: inst=%h got %h expected %h", i, insts[i], o_imm, imms[i]);
      end
      pc = pc + 32'h4;
      issue_dnpc(pc);
    end
  endtask

  task automatic test_pc_valid_ignore();
    do_reset();
    run_fetch("ign_first", RESET_PC, 32'h0000_0013, 0, 0);
    issue_dnpc(32'h8000_0004);
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    i_pc_valid  = 1'b1;
    i_dnpc      = 32'hDEAD_BEE0;
    step();
    vectors++;
    if (o_mem_req !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL ign_wait: req=%b valid=%b pc=%h expected 0/0/80000004",
               o_mem_req, o_valid, o_pc);
    end
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0030_0093;
    step();
    i_mem_rvalid = 1'b0;
    i_dnpc       = 32'hCAFE_0000;
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL ign_valid: valid=%b pc=%h expected 1/80000004", o_valid, o_pc);
    end
    step();
    i_pc_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_mem_req !== 1'b0 || o_pc !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL ign_done: valid=%b req=%b pc=%h expected 0/0/80000004",
               o_valid, o_mem_req, o_pc);
    end
    issue_dnpc(32'h8000_0010);
    vectors++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL ign_next: req=%b addr=%h expected 1/80000010", o_mem_req, o_mem_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    run_fetch("rst_first", RESET_PC, 32'h0000_0013, 0, 0);
    issue_dnpc(32'h8000_0100);
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    i_reset     = 1'b1;
    step();
    i_reset      = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0070_0093;
    step();
    i_mem_rvalid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_late_rvalid: valid=%b inst=%h expected 0/0", o_valid, o_inst);
    end
    vectors++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL rst_refetch: req=%b addr=%h expected 1/%h", o_mem_req, o_mem_addr, RESET_PC);
    end
    run_fetch("rst_refetch", RESET_PC, 32'h0080_0093, 1, 1);
  endtask

  task automatic test_dnpc_align();
    do_reset();
    run_fetch("align_first", RESET_PC, 32'h0000_0013, 0, 0);
    issue_dnpc(32'h8000_0002);
`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
    vectors++;
    if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_pc !== RESET_PC) begin
      miscompares++;
      $display("FAIL align_fault: fault=%b req=%b pc=%h expected 1/0/%h",
               o_fault, o_mem_req, o_pc, RESET_PC);
    end
    i_mem_ready  = 1'b1;
    i_mem_rvalid = 1'b1;
    i_pc_valid   = 1'b1;
    i_dnpc       = 32'h8000_0004;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL align_sticky%0d: fault=%b req=%b valid=%b expected 1/0/0",
                 k, o_fault, o_mem_req, o_valid);
      end
    end
    do_reset();
    vectors++;
    if (o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL align_clear: fault=%b expected 0", o_fault);
    end
`else
    vectors++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8000_0002 || o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL align_unchecked: req=%b addr=%h fault=%b expected 1/80000002/0",
               o_mem_req, o_mem_addr, o_fault);
    end
    run_fetch("align_unchecked", 32'h8000_0002, 32'h0000_0013, 0, 0);
`endif
  endtask

  task automatic test_random_fetch();
    logic [6:0]  ops [12];
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] next_pc;
    int          idle;
    ops = '{7'h13, 7'h67, 7'h03, 7'h73, 7'h37, 7'h17,
            7'h6F, 7'h23, 7'h63, 7'h33, 7'h0B, 7'h7F};
    do_reset();
    pc = RESET_PC;
    for (int n = 0; n < 40; n++) begin
      inst      = $urandom;
      inst[6:0] = ops[$urandom_range(0, 11)];
      run_fetch("random", pc, inst, $urandom_range(0, 3), $urandom_range(0, 3));
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        step();
        vectors++;
        if (o_valid !== 1'b0 || o_mem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL random_idle: valid=%b req=%b expected 0/0", o_valid, o_mem_req);
        end
      end
      next_pc = $urandom;
`ifdef YSYX_24110006_IFU_ALIGN_CHECK_EN
      next_pc[1:0] = 2'b00;
`endif
      issue_dnpc(next_pc);
      pc = next_pc;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset      = 1'b0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;
    i_pc_valid   = 1'b0;
    i_dnpc       = 32'h0;
    step();
    test_reset();
    test_basic_fetch();
    test_ready_stall();
    test_imm_table();
    test_pc_valid_ignore();
    test_reset_in_wait();
    test_dnpc_align();
    test_random_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
